// File: rtl/bus_cycle_initiator_if.sv
// Processor-side bus bundle: the single-request command channel plus the
// multiplexed bus pins driven by the cycle initiator.
interface bus_cycle_initiator_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  // command channel
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  // bus pins
  logic              bus_ale;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rd_n;
  logic              bus_wr_n;
  logic [DATA_W-1:0] bus_dout;
  logic              bus_dout_oe;
  logic [DATA_W-1:0] bus_din;
  logic              bus_ready;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, bus_din, bus_ready,
    output req_ready, done, err, rdata,
    output bus_ale, bus_addr, bus_rd_n, bus_wr_n, bus_dout, bus_dout_oe
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, bus_din, bus_ready,
    input  req_ready, done, err, rdata,
    input  bus_ale, bus_addr, bus_rd_n, bus_wr_n, bus_dout, bus_dout_oe
  );
endinterface

// File: rtl/bus_cycle_initiator.sv
// Bus cycle initiator: converts one accepted valid/ready command into a
// T1/T2/Tw/T4 bus cycle, stretching with wait states until the responder
// signals ready and aborting with err after TIMEOUT wait states.
// Every output is either a register or a decode of the state register, so
// bus_ready/bus_din never reach an output combinationally.
module bus_cycle_initiator #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 32   // legal range 1..255
) (
  input logic                    clk,
  input logic                    reset_n,
  bus_cycle_initiator_if.master  bus
);

  localparam int                CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                abort_q, abort_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic                strobe;

  // State and datapath registers; reset drops any cycle in flight at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      abort_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state: accept in IDLE, sample bus_ready only at the end of T2/Tw.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    abort_d = abort_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
          abort_d = 1'b0;
          state_d = S_T1;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: begin
        if (bus.bus_ready) begin
          if (!we_q) rdata_d = bus.bus_din;
          state_d = S_T4;
        end else begin
          wait_d  = '0;
          state_d = S_TW;
        end
      end
      S_TW: begin
        if (bus.bus_ready) begin
          if (!we_q) rdata_d = bus.bus_din;
          state_d = S_T4;
        end else if (wait_q == LAST_WAIT) begin
          // Dead responder: finish the cycle with the abort flag, rdata untouched.
          abort_d = 1'b1;
          state_d = S_T4;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_T4:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are live in T2 and every wait state; ALE never overlaps them.
  assign strobe          = (state_q == S_T2) || (state_q == S_TW);
  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.bus_ale     = (state_q == S_T1);
  assign bus.bus_addr    = addr_q;
  assign bus.bus_rd_n    = !(strobe && !we_q);
  assign bus.bus_wr_n    = !(strobe && we_q);
  assign bus.bus_dout_oe = strobe && we_q;
  assign bus.bus_dout    = wdata_q;
  assign bus.done        = (state_q == S_T4);
  assign bus.err         = (state_q == S_T4) && abort_q;
  assign bus.rdata       = rdata_q;

endmodule

// File: tb/tb_bus_cycle_initiator.sv
// Directed bench for bus_cycle_initiator: a per-cycle monitor counts strobe
// and handshake activity while a small responder model drives bus_ready.
module tb_bus_cycle_initiator;

  logic clk = 1'b0;
  logic reset_n;

  bus_cycle_initiator_if #(.ADDR_W(20), .DATA_W(16)) bif ();

  bus_cycle_initiator #(.ADDR_W(20), .DATA_W(16), .TIMEOUT(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // monitor state
  int          n_acc, n_done, lat_cnt, done_lat;
  int          ale_cnt, rd_cnt, wr_cnt, oe_cnt, rr_low, viol, strb_cnt;
  bit          lat_run, last_err;
  int          acc_cyc [4];
  logic [19:0] ale_log [4];
  logic [19:0] done_addr;
  logic [15:0] exp_dout;

  // responder model controls
  bit tied, stuck, pulse_t1;
  int nwait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    n_acc = 0; n_done = 0; lat_cnt = 0; done_lat = 0;
    ale_cnt = 0; rd_cnt = 0; wr_cnt = 0; oe_cnt = 0; rr_low = 0; viol = 0;
    strb_cnt = 0; lat_run = 0; last_err = 0; done_addr = '0;
    for (int k = 0; k < 4; k++) begin
      acc_cyc[k] = 0;
      ale_log[k] = '0;
    end
  endtask

  // One clock: set bus_ready from the responder model, cross the posedge,
  // then sample everything at the following negedge.
  task automatic step();
    bit acc;
    acc = bif.req_valid && bif.req_ready;
    if (!bif.bus_rd_n || !bif.bus_wr_n) strb_cnt++;
    else strb_cnt = 0;
    if (tied)                          bif.bus_ready = 1'b1;
    else if (pulse_t1 && bif.bus_ale)  bif.bus_ready = 1'b1;
    else                               bif.bus_ready = !stuck && (strb_cnt > nwait);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (acc) begin
      lat_run = 1;
      lat_cnt = 0;
      if (n_acc < 4) acc_cyc[n_acc] = cyc;
      n_acc++;
    end
    if (lat_run) lat_cnt++;
    if (bif.bus_ale) begin
      if (ale_cnt < 4) ale_log[ale_cnt] = bif.bus_addr;
      ale_cnt++;
    end
    if (!bif.bus_rd_n)   rd_cnt++;
    if (!bif.bus_wr_n)   wr_cnt++;
    if (bif.bus_dout_oe) oe_cnt++;
    if (!bif.req_ready)  rr_low++;
    if (bif.bus_dout_oe && bif.bus_ale)          viol++;
    if (bif.bus_dout_oe && bif.bus_dout !== exp_dout) viol++;
    if (bif.done) begin
      n_done++;
      done_lat  = lat_cnt;
      lat_run   = 0;
      last_err  = bif.err;
      done_addr = bif.bus_addr;
    end
  endtask

  task automatic do_cmd(input bit we, input logic [19:0] addr, input logic [15:0] wd,
                        input int maxc);
    clear_mon();
    bif.req_we    = we;
    bif.req_addr  = addr;
    bif.req_wdata = wd;
    exp_dout      = wd;
    bif.req_valid = 1'b1;
    for (int i = 0; i < maxc && n_acc == 0; i++) step();
    bif.req_valid = 1'b0;
    chk("accepted", 32'(n_acc), 32'd1);
    for (int i = 0; i < maxc && n_done == 0; i++) step();
    repeat (3) step();
    chk("one_done_pulse", 32'(n_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end expected finish");
    $fatal(1);
  end

  initial begin
    reset_n       = 1'b0;
    bif.req_valid = 1'b0;
    bif.req_we    = 1'b0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    bif.bus_din   = '0;
    bif.bus_ready = 1'b0;
    tied = 1; stuck = 0; pulse_t1 = 0; nwait = 0;
    clear_mon();
    exp_dout = '0;

    // reset values while reset_n is held low
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bif.req_ready),   32'd1);
    chk("rst_done",      32'(bif.done),        32'd0);
    chk("rst_err",       32'(bif.err),         32'd0);
    chk("rst_rdata",     32'(bif.rdata),       32'd0);
    chk("rst_ale",       32'(bif.bus_ale),     32'd0);
    chk("rst_addr",      32'(bif.bus_addr),    32'd0);
    chk("rst_rd_n",      32'(bif.bus_rd_n),    32'd1);
    chk("rst_wr_n",      32'(bif.bus_wr_n),    32'd1);
    chk("rst_dout",      32'(bif.bus_dout),    32'd0);
    chk("rst_dout_oe",   32'(bif.bus_dout_oe), 32'd0);
    reset_n = 1'b1;
    step();

    // zero-wait read: T1,T2,T4 -> done in 3rd cycle after accept,
    // req_ready low for exactly those three cycles
    tied = 1; bif.bus_din = 16'hBEEF;
    do_cmd(1'b0, 20'h12345, 16'h0000, 20);
    chk("t1_latency",  32'(done_lat), 32'd3);
    chk("t1_err",      32'(last_err), 32'd0);
    chk("t1_rdata",    32'(bif.rdata), 32'hBEEF);
    chk("t1_ale_cyc",  32'(ale_cnt),  32'd1);
    chk("t1_ale_addr", 32'(ale_log[0]), 32'h12345);
    chk("t1_rd_cyc",   32'(rd_cnt),   32'd1);
    chk("t1_wr_cyc",   32'(wr_cnt),   32'd0);
    chk("t1_oe_cyc",   32'(oe_cnt),   32'd0);
    chk("t1_rr_low",   32'(rr_low),   32'd3);
    chk("t1_t4_addr",  32'(done_addr), 32'h12345);

    // write with 3 wait states: strobe in T2 + 3 Tw = 4 cycles, done 6 after accept
    tied = 0; stuck = 0; nwait = 3; bif.bus_din = 16'h0BAD;
    do_cmd(1'b1, 20'h00ABC, 16'hA55A, 40);
    chk("t2_latency", 32'(done_lat), 32'd6);
    chk("t2_err",     32'(last_err), 32'd0);
    chk("t2_wr_cyc",  32'(wr_cnt),   32'd4);
    chk("t2_oe_cyc",  32'(oe_cnt),   32'd4);
    chk("t2_rd_cyc",  32'(rd_cnt),   32'd0);
    chk("t2_dout_ale_viol", 32'(viol), 32'd0);
    chk("t2_rdata_kept", 32'(bif.rdata), 32'hBEEF);

    // dead responder: T2 + 32 Tw, done at cycle 35 with err, rdata untouched
    tied = 0; stuck = 1; bif.bus_din = 16'h1111;
    do_cmd(1'b0, 20'h0F0F0, 16'h0000, 100);
    chk("t3_rd_cyc",  32'(rd_cnt),   32'd33);
    chk("t3_latency", 32'(done_lat), 32'd35);
    chk("t3_err",     32'(last_err), 32'd1);
    chk("t3_rdata",   32'(bif.rdata), 32'hBEEF);

    // next command after an abort is normal
    tied = 1; stuck = 0; bif.bus_din = 16'h2222;
    do_cmd(1'b0, 20'h00002, 16'h0000, 20);
    chk("t3b_latency", 32'(done_lat), 32'd3);
    chk("t3b_err",     32'(last_err), 32'd0);
    chk("t3b_rdata",   32'(bif.rdata), 32'h2222);

    // slow responder: ready on the 16th strobe cycle -> 15 Tw, no abort
    tied = 0; nwait = 15; bif.bus_din = 16'h4444;
    do_cmd(1'b0, 20'h44444, 16'h0000, 60);
    chk("t4_latency", 32'(done_lat), 32'd18);
    chk("t4_err",     32'(last_err), 32'd0);
    chk("t4_rdata",   32'(bif.rdata), 32'h4444);

    // req_valid held across two commands: accepts 4 cycles apart, in order
    clear_mon();
    tied = 1; bif.bus_din = 16'h5A5A;
    bif.req_we = 1'b0; bif.req_addr = 20'h00111; bif.req_valid = 1'b1;
    for (int i = 0; i < 20 && n_acc < 2; i++) begin
      step();
      if (n_acc == 1) bif.req_addr = 20'h00222;
    end
    bif.req_valid = 1'b0;
    for (int i = 0; i < 20 && n_done < 2; i++) step();
    repeat (2) step();
    chk("t5_accepts",  32'(n_acc), 32'd2);
    chk("t5_spacing",  32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    chk("t5_dones",    32'(n_done), 32'd2);
    chk("t5_order0",   32'(ale_log[0]), 32'h00111);
    chk("t5_order1",   32'(ale_log[1]), 32'h00222);

    // bus_ready high only in T1 must be ignored: T2 sees low -> one Tw
    tied = 0; pulse_t1 = 1; nwait = 1; bif.bus_din = 16'h7777;
    do_cmd(1'b0, 20'h00333, 16'h0000, 20);
    pulse_t1 = 0;
    chk("t5b_latency", 32'(done_lat), 32'd4);
    chk("t5b_rd_cyc",  32'(rd_cnt),   32'd2);
    chk("t5b_err",     32'(last_err), 32'd0);

    // asynchronous reset in the middle of a wait state
    clear_mon();
    tied = 0; stuck = 1; bif.bus_din = 16'h9999;
    bif.req_we = 1'b0; bif.req_addr = 20'h0ABCD; bif.req_valid = 1'b1;
    for (int i = 0; i < 20 && n_acc == 0; i++) step();
    bif.req_valid = 1'b0;
    chk("t6_accepted", 32'(n_acc), 32'd1);
    repeat (4) step();   // T2, Tw, Tw, Tw
    chk("t6_pre_rd_n", 32'(bif.bus_rd_n), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rd_n",     32'(bif.bus_rd_n),  32'd1);
    chk("t6_ale",      32'(bif.bus_ale),   32'd0);
    chk("t6_done",     32'(bif.done),      32'd0);
    chk("t6_err",      32'(bif.err),       32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    stuck = 0; tied = 1;
    step();
    chk("t6_req_ready", 32'(bif.req_ready), 32'd1);
    chk("t6_no_done",   32'(n_done),        32'd0);
    chk("t6_rdata_rst", 32'(bif.rdata),     32'd0);

    bif.bus_din = 16'h6666;
    do_cmd(1'b0, 20'h00666, 16'h0000, 20);
    chk("t6b_rdata",   32'(bif.rdata), 32'h6666);
    chk("t6b_latency", 32'(done_lat),  32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
